// File: rtl/voice_pkg.sv
// Shared definitions for the voice frame controller: state encoding,
// timeout result code and default sizing.
package voice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_MATCH   = 3'd2,
        ST_TX_REQ  = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_e;

    localparam logic [6:0] RESULT_TIMEOUT      = 7'h7F;
    localparam int         DEFAULT_FRAME_LEN   = 16;
    localparam int         DEFAULT_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/voice_frame_ctrl_if.sv
// Byte stream, recognizer handshake, sample read port and UART transmit
// request of the voice frame controller.
interface voice_frame_ctrl_if
    import voice_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) ();
    localparam int AW = $clog2(FRAME_LEN);

    logic [7:0]    rx_data;
    logic          rx_vld;
    logic          frame_err;
    logic          match_start;
    logic          match_done;
    logic [6:0]    match_result;
    logic [AW-1:0] sample_raddr;
    logic [7:0]    sample_rdata;
    logic          tx_send;
    logic [7:0]    tx_data;
    logic          tx_busy;

    // master is the controller, slave is the UART/recognizer side
    modport master (
        input  rx_data, rx_vld, frame_err, match_done, match_result,
               sample_raddr, tx_busy,
        output match_start, sample_rdata, tx_send, tx_data
    );

    modport slave (
        output rx_data, rx_vld, frame_err, match_done, match_result,
               sample_raddr, tx_busy,
        input  match_start, sample_rdata, tx_send, tx_data
    );
endinterface

// File: rtl/frame_buf.sv
// FRAME_LEN x 8 sample store: one synchronous write port, one
// asynchronous read port, contents not reset.
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/voice_frame_ctrl.sv
// Collects a frame of UART samples, hands it to the recognizer, and sends
// the recognized class (or the timeout code) back over the UART.
module voice_frame_ctrl
    import voice_pkg::*;
#(
    parameter int FRAME_LEN   = DEFAULT_FRAME_LEN,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,   // active-high despite the name
    voice_frame_ctrl_if.master   bus_if,
    output logic [6:0]           result_o,
    output logic                 result_vld_o,
    output logic [2:0]           state_o,
    output logic                 overrun_o,
    output logic [7:0]           err_cnt_o
);
    localparam int            AW      = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST    = AW'(FRAME_LEN - 1);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [15:0]   cnt_q;
    logic [6:0]    result_q;
    logic          result_vld_q, match_start_q, tx_send_q, overrun_q;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          good_byte, accepting, buf_we;

    assign good_byte = bus_if.rx_vld & ~bus_if.frame_err;
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign buf_we    = good_byte & accepting & ~rst_n_i;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    frame_buf #(.DEPTH(FRAME_LEN), .AW(AW)) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus_if.rx_data),
        .raddr_i (bus_if.sample_raddr),
        .rdata_o (bus_if.sample_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            result_vld_q  <= 1'b0;
            match_start_q <= 1'b0;
            tx_send_q     <= 1'b0;
            overrun_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            match_start_q <= 1'b0;
            result_vld_q  <= 1'b0;
            if (bus_if.rx_vld && bus_if.frame_err) err_cnt_q <= err_cnt_d;
            if (good_byte && !accepting) overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (good_byte) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LAST) begin
                            state_q       <= ST_MATCH;
                            match_start_q <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_MATCH: begin
                    // a done strobe wins over a simultaneous timeout
                    if (bus_if.match_done) begin
                        result_q     <= bus_if.match_result;
                        result_vld_q <= 1'b1;
                        tx_send_q    <= 1'b1;
                        state_q      <= ST_TX_REQ;
                    end else if (cnt_q == TO_LAST) begin
                        result_q     <= RESULT_TIMEOUT;
                        result_vld_q <= 1'b1;
                        tx_send_q    <= 1'b1;
                        state_q      <= ST_TX_REQ;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_TX_REQ: begin
                    if (bus_if.tx_busy) begin
                        tx_send_q <= 1'b0;
                        state_q   <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (!bus_if.tx_busy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_if.match_start = match_start_q;
    assign bus_if.tx_send     = tx_send_q;
    assign bus_if.tx_data     = {1'b0, result_q};
    assign result_o           = result_q;
    assign result_vld_o       = result_vld_q;
    assign state_o            = state_q;
    assign overrun_o          = overrun_q;
    assign err_cnt_o          = err_cnt_q;
endmodule

// File: tb/tb_voice_frame_ctrl.sv
// Directed bench for voice_frame_ctrl: frame collection, match handshake,
// timeout, frame errors, overrun and mid-frame reset.
module tb_voice_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] result;
    logic       result_vld;
    logic [2:0] state;
    logic       overrun;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int entry_cyc;
    int starts;

    voice_frame_ctrl_if #(.FRAME_LEN(16)) bus ();

    voice_frame_ctrl #(.FRAME_LEN(16), .TIMEOUT_CYC(4096)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst),
        .bus_if       (bus),
        .result_o     (result),
        .result_vld_o (result_vld),
        .state_o      (state),
        .overrun_o    (overrun),
        .err_cnt_o    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ferr);
        bus.rx_data   = d;
        bus.frame_err = ferr;
        bus.rx_vld    = 1'b1;
        step();
        bus.rx_vld    = 1'b0;
        bus.frame_err = 1'b0;
    endtask

    initial begin
        bus.rx_data      = '0;
        bus.rx_vld       = 1'b0;
        bus.frame_err    = 1'b0;
        bus.match_done   = 1'b0;
        bus.match_result = '0;
        bus.sample_raddr = '0;
        bus.tx_busy      = 1'b0;
        repeat (3) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_match_start", 32'(bus.match_start), 0);
        chk("rst_tx_send", 32'(bus.tx_send), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_result_vld", 32'(result_vld), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        step();

        // frame 0x00..0x0F, recognizer answers 0x09
        send_byte(8'h00, 1'b0);
        chk("s1_collect", 32'(state), 1);
        for (int i = 1; i < 15; i++) send_byte(8'(i), 1'b0);
        chk("s1_no_early_start", 32'(bus.match_start), 0);
        send_byte(8'h0F, 1'b0);
        chk("s1_match_start", 32'(bus.match_start), 1);
        chk("s1_state_match", 32'(state), 2);
        for (int i = 0; i < 16; i++) begin
            bus.sample_raddr = 4'(i);
            step();
            chk($sformatf("s2_rdata_%0d", i), 32'(bus.sample_rdata), 32'(i));
        end
        chk("s1_start_one_cycle", 32'(bus.match_start), 0);
        bus.match_done   = 1'b1;
        bus.match_result = 7'h09;
        step();
        bus.match_done = 1'b0;
        chk("s1_result", 32'(result), 32'h09);
        chk("s1_result_vld", 32'(result_vld), 1);
        chk("s1_tx_send", 32'(bus.tx_send), 1);
        chk("s1_tx_data", 32'(bus.tx_data), 32'h09);
        chk("s1_state_tx_req", 32'(state), 3);
        step();
        chk("s1_vld_pulse", 32'(result_vld), 0);
        chk("s1_tx_send_hold", 32'(bus.tx_send), 1);
        bus.tx_busy = 1'b1;
        step();
        chk("s1_tx_send_drop", 32'(bus.tx_send), 0);
        chk("s1_state_tx_wait", 32'(state), 4);
        step();
        chk("s1_wait_busy", 32'(state), 4);
        bus.tx_busy = 1'b0;
        step();
        chk("s1_state_idle", 32'(state), 0);

        // stray done strobe in IDLE has no effect
        bus.match_done   = 1'b1;
        bus.match_result = 7'h33;
        step();
        bus.match_done = 1'b0;
        chk("ign_done_result", 32'(result), 32'h09);
        chk("ign_done_vld", 32'(result_vld), 0);
        chk("ign_done_state", 32'(state), 0);

        // frame with 3 stop-bit errors interleaved
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 8 || i == 13) send_byte(8'hEE, 1'b1);
            send_byte(8'(8'h10 + i), 1'b0);
            if (i == 14) chk("s4_not_done_yet", 32'(state), 1);
        end
        entry_cyc = cyc;
        chk("s4_err_cnt", 32'(err_cnt), 3);
        chk("s4_state_match", 32'(state), 2);

        // byte during MATCH is dropped and flagged
        bus.sample_raddr = 4'd0;
        send_byte(8'hAA, 1'b0);
        chk("s5_overrun", 32'(overrun), 1);
        chk("s5_buf_unchanged", 32'(bus.sample_rdata), 32'h10);
        bus.sample_raddr = 4'd3;
        #1;
        chk("s4_buf_entry3", 32'(bus.sample_rdata), 32'h13);

        // no done strobe: timeout result 4096 cycles after MATCH entry
        while (!result_vld && (cyc - entry_cyc) < 5000) step();
        chk("s3_timeout_latency", 32'(cyc - entry_cyc), 4096);
        chk("s3_result", 32'(result), 32'h7F);
        chk("s3_tx_data", 32'(bus.tx_data), 32'h7F);
        chk("s3_tx_send", 32'(bus.tx_send), 1);
        bus.tx_busy = 1'b1;
        step();
        bus.tx_busy = 1'b0;
        step();
        chk("s3_state_idle", 32'(state), 0);
        chk("s5_overrun_sticky", 32'(overrun), 1);

        // reset after 8 bytes, then a full new frame
        for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), 1'b0);
        chk("s6_collect", 32'(state), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_rst_state", 32'(state), 0);
        chk("s6_rst_overrun", 32'(overrun), 0);
        chk("s6_rst_err_cnt", 32'(err_cnt), 0);
        chk("s6_rst_result", 32'(result), 0);
        starts = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h50 + i), 1'b0);
            if (bus.match_start) starts++;
        end
        chk("s6_start_count", 32'(starts), 1);
        chk("s6_start_last", 32'(bus.match_start), 1);
        bus.sample_raddr = 4'd0;
        #1;
        chk("s6_buf_first", 32'(bus.sample_rdata), 32'h50);
        bus.sample_raddr = 4'd15;
        #1;
        chk("s6_buf_last", 32'(bus.sample_rdata), 32'h5F);

        // error counter saturates at 255
        for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b1);
        chk("err_cnt_sat", 32'(err_cnt), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
